duty_button_conditioner: RTL and testbench



---
 rtl/pwm_pkg.sv | 23 ++
 rtl/button_channel.sv | 104 ++++++++++
 rtl/duty_button_conditioner.sv | 71 +++++++
 tb/tb_duty_button_conditioner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM block family: channel FSM states,
// counter sizing helper and default timing parameters.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } chan_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 4096;
  localparam int DEF_REPEAT_PERIOD   = 1024;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, debounce/repeat FSM, registered pulse and held.
// Pulse appears DEBOUNCE_CYCLES+1 cycles after the raw edge; no backpressure.
module button_channel
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  output logic pulse_o,
  output logic held_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DBC_TERM   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DELAY_TERM = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PER_TERM   = CW'(REPEAT_PERIOD);

  logic          sync1_q, sync2_q;
  chan_state_t   state_q, state_d;
  logic [CW-1:0] dbc_q, dbc_d;
  logic [CW-1:0] rpt_q, rpt_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] dbc_inc, rpt_inc, rpt_term;
  logic          s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v,
                                            input logic [CW-1:0] term);
    return (v >= term) ? term : v + 1'b1;
  endfunction

  assign s        = sync2_q;
  assign rpt_term = (state_q == ST_HELD) ? DELAY_TERM : PER_TERM;
  assign dbc_inc  = sat_inc(dbc_q, DBC_TERM);
  assign rpt_inc  = sat_inc(rpt_q, rpt_term);

  always_comb begin
    state_d = state_q;
    dbc_d   = dbc_q;
    rpt_d   = rpt_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rpt_d = '0;
        if (!s) begin
          dbc_d = '0;
        end else if (dbc_inc == DBC_TERM) begin
          state_d = ST_HELD;
          dbc_d   = '0;
          pulse_d = 1'b1;
        end else begin
          dbc_d = dbc_inc;
        end
      end
      ST_HELD, ST_REPEAT: begin
        // A completed release beats a repeat pulse landing on the same edge.
        if (!s && dbc_inc == DBC_TERM) begin
          state_d = ST_IDLE;
          dbc_d   = '0;
          rpt_d   = '0;
        end else begin
          dbc_d = s ? '0 : dbc_inc;
          if (rpt_inc == rpt_term) begin
            state_d = ST_REPEAT;
            rpt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            rpt_d = rpt_inc;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        dbc_d   = '0;
        rpt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      dbc_q   <= '0;
      rpt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      dbc_q   <= dbc_d;
      rpt_q   <= rpt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign held_o  = (state_q != ST_IDLE);

endmodule

// File: rtl/duty_button_conditioner.sv
// Increase/decrease button front end for the PWM generator with conflict suppression.
// First pulse DEBOUNCE_CYCLES+2 cycles after the raw edge; no backpressure.
module duty_button_conditioner
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_held,
  output logic dec_held
);

  logic inc_p, inc_h, dec_p, dec_h;
  logic inc_pulse_q, dec_pulse_q, inc_held_q, dec_held_q;
  logic inc_pulse_d, dec_pulse_d;

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_inc (
    .clk      (clk),
    .rst      (rst),
    .btn_raw_i(btn_inc_raw),
    .pulse_o  (inc_p),
    .held_o   (inc_h)
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_dec (
    .clk      (clk),
    .rst      (rst),
    .btn_raw_i(btn_dec_raw),
    .pulse_o  (dec_p),
    .held_o   (dec_h)
  );

  // Any overlap between the two buttons means intent is ambiguous: emit nothing.
  assign inc_pulse_d = inc_p & ~dec_p & ~dec_h;
  assign dec_pulse_d = dec_p & ~inc_p & ~inc_h;

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
      inc_held_q  <= 1'b0;
      dec_held_q  <= 1'b0;
    end else begin
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
      inc_held_q  <= inc_h;
      dec_held_q  <= dec_h;
    end
  end

  assign inc_pulse = inc_pulse_q;
  assign dec_pulse = dec_pulse_q;
  assign inc_held  = inc_held_q;
  assign dec_held  = dec_held_q;

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Directed bench for duty_button_conditioner with DEBOUNCE=4, DELAY=20, PERIOD=8.
// Cycle c is sampled 1ns after edge c; raw inputs for cycle c are driven before edge c.
module tb_duty_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_inc_raw = 1'b0;
  logic btn_dec_raw = 1'b0;
  logic inc_pulse, dec_pulse, inc_held, dec_held;

  int errors = 0;
  int checks = 0;

  duty_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .inc_held   (inc_held),
    .dec_held   (dec_held)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({inc_pulse, dec_pulse, inc_held, dec_held} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs c=%0d got=%b exp=0000", c,
                 {inc_pulse, dec_pulse, inc_held, dec_held});
      end
    end
    do_reset();
  endtask

  task automatic test_clean_tap();
    logic ep, eh;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      btn_inc_raw = (c < 10);
      tick();
      ep = (c == 6);
      eh = (c >= 6 && c <= 15);
      checks++;
      if (inc_pulse !== ep) begin
        errors++;
        $display("FAIL tap_inc_pulse c=%0d got=%b exp=%b", c, inc_pulse, ep);
      end
      checks++;
      if (inc_held !== eh) begin
        errors++;
        $display("FAIL tap_inc_held c=%0d got=%b exp=%b", c, inc_held, eh);
      end
      checks++;
      if (dec_pulse !== 1'b0) begin
        errors++;
        $display("FAIL tap_dec_pulse c=%0d got=%b exp=0", c, dec_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    logic [8:0] pat;
    logic ep, eh;
    pat = 9'b111101101; // bit c is the raw value for cycle c
    do_reset();
    for (int c = 0; c < 35; c++) begin
      btn_dec_raw = (c < 9) ? pat[c] : (c < 20);
      tick();
      ep = (c == 11);
      eh = (c >= 11 && c <= 25);
      checks++;
      if (dec_pulse !== ep) begin
        errors++;
        $display("FAIL bounce_dec_pulse c=%0d got=%b exp=%b", c, dec_pulse, ep);
      end
      checks++;
      if (dec_held !== eh) begin
        errors++;
        $display("FAIL bounce_dec_held c=%0d got=%b exp=%b", c, dec_held, eh);
      end
      checks++;
      if (inc_pulse !== 1'b0) begin
        errors++;
        $display("FAIL bounce_inc_pulse c=%0d got=%b exp=0", c, inc_pulse);
      end
    end
  endtask

  task automatic test_hold_repeat();
    logic ep, eh;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      btn_inc_raw = (c < 60);
      tick();
      ep = (c == 6 || c == 26 || c == 34 || c == 42 || c == 50 || c == 58);
      eh = (c >= 6 && c <= 65);
      checks++;
      if (inc_pulse !== ep) begin
        errors++;
        $display("FAIL hold_inc_pulse c=%0d got=%b exp=%b", c, inc_pulse, ep);
      end
      checks++;
      if (inc_held !== eh) begin
        errors++;
        $display("FAIL hold_inc_held c=%0d got=%b exp=%b", c, inc_held, eh);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic eh;
    do_reset();
    for (int c = 0; c < 45; c++) begin
      btn_inc_raw = (c < 30);
      btn_dec_raw = (c < 30);
      tick();
      eh = (c >= 6 && c <= 35);
      checks++;
      if ({inc_pulse, dec_pulse} !== 2'b00) begin
        errors++;
        $display("FAIL simul_pulses c=%0d got=%b exp=00", c, {inc_pulse, dec_pulse});
      end
      checks++;
      if ({inc_held, dec_held} !== {eh, eh}) begin
        errors++;
        $display("FAIL simul_held c=%0d got=%b exp=%b%b", c, {inc_held, dec_held}, eh, eh);
      end
    end
  endtask

  task automatic test_release_glitch();
    logic ep, eh;
    do_reset();
    for (int c = 0; c < 66; c++) begin
      btn_inc_raw = (c < 50) && !(c == 30 || c == 31);
      tick();
      ep = (c == 6 || c == 26 || c == 34 || c == 42 || c == 50);
      eh = (c >= 6 && c <= 55);
      checks++;
      if (inc_pulse !== ep) begin
        errors++;
        $display("FAIL glitch_inc_pulse c=%0d got=%b exp=%b", c, inc_pulse, ep);
      end
      checks++;
      if (inc_held !== eh) begin
        errors++;
        $display("FAIL glitch_inc_held c=%0d got=%b exp=%b", c, inc_held, eh);
      end
    end
  endtask

  task automatic test_mid_repeat_reset();
    logic ep, eh;
    do_reset();
    for (int c = 0; c < 62; c++) begin
      btn_inc_raw = (c < 50);
      rst = (c == 30);
      tick();
      ep = (c == 6 || c == 26 || c == 37);
      eh = (c >= 6 && c <= 29) || (c >= 37 && c <= 55);
      checks++;
      if (inc_pulse !== ep) begin
        errors++;
        $display("FAIL rstmid_inc_pulse c=%0d got=%b exp=%b", c, inc_pulse, ep);
      end
      checks++;
      if (inc_held !== eh) begin
        errors++;
        $display("FAIL rstmid_inc_held c=%0d got=%b exp=%b", c, inc_held, eh);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_tap();
    test_bounce();
    test_hold_repeat();
    test_simultaneous();
    test_release_glitch();
    test_mid_repeat_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
